axi_ram_model: RTL and testbench
================================

AXI_RAM_MODEL -- requirements
Module: axi_ram_model

Interface
REQ-001 The module SHALL have parameter AXI_WIDTH, default 128, meaning word width in bits (multiple of 8).
REQ-002 The module SHALL have parameter AXI_ADDR_WIDTH, default 32, meaning AXI byte-address width.
REQ-003 The module SHALL have parameter DEPTH_LOG2, default 12, meaning log2 of implemented word count.
REQ-004 The module SHALL have derived localparams LSB = $clog2(AXI_WIDTH)-3 and AW = AXI_ADDR_WIDTH-LSB.
REQ-005 The module SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 The module SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 The module SHALL have ports ren  input  1  read request; raddr  input  AW  word read address.
REQ-008 The module SHALL have port rdata  output  AXI_WIDTH  read data.
REQ-009 The module SHALL have ports wen  input  1  write request; waddr  input  AW  word write address; wdata  input  AXI_WIDTH  write data; wstrb  input  AXI_WIDTH/8  byte enables.
REQ-010 The module SHALL have ports bd_en  input  1  backdoor access; bd_we  input  1  backdoor write (1) / read (0); bd_addr  input  AW  word address; bd_wdata  input  AXI_WIDTH  data; bd_rdata  output  AXI_WIDTH  backdoor read data.
REQ-011 The module SHALL have ports rd_count and wr_count  output  32  accepted-access counters; oor_err  output  1  sticky out-of-range flag.

Function
REQ-012 The module SHALL return rdata exactly one cycle after a cycle with ren=1: rdata = mem[raddr] sampled at that edge.
REQ-013 rdata SHALL hold its last value in cycles after ren=0.
REQ-014 On wen=1 the module SHALL update only the bytes of mem[waddr] whose wstrb bit is 1; wstrb=0 SHALL leave the word unchanged but still count.
REQ-015 Read and write to the same address in the same cycle SHALL be read-first: rdata returns the pre-write contents.
REQ-016 A backdoor write (bd_en=1, bd_we=1) SHALL write all bytes of mem[bd_addr].
REQ-017 A backdoor read (bd_en=1, bd_we=0) SHALL present bd_rdata one cycle later, read-first, and hold it otherwise.
REQ-018 When wen and a backdoor write target the same address in one cycle, the port write SHALL win.
REQ-019 Backdoor accesses SHALL NOT change rd_count, wr_count or oor_err.
REQ-020 Any address with a nonzero bit at or above DEPTH_LOG2 SHALL be out of range.
REQ-021 An out-of-range write SHALL be dropped.
REQ-022 An out-of-range read SHALL return all zeros.
REQ-023 An out-of-range port access (ren or wen) SHALL set oor_err, which stays 1 until reset.
REQ-024 rd_count SHALL increment once per ren=1 cycle.
REQ-025 wr_count SHALL increment once per wen=1 cycle.
REQ-026 Both counters SHALL wrap from 2^32-1 to 0.
REQ-027 The module SHALL have no internal stall; it accepts a read, a write and a backdoor access every cycle.

Reset
REQ-028 On rst assertion, asynchronously: rdata=0, bd_rdata=0, rd_count=0, wr_count=0, oor_err=0.
REQ-029 Memory contents SHALL NOT be cleared by reset.
REQ-030 A read issued in the cycle where rst asserts SHALL be discarded: rdata reads 0 after reset release until the next ren.
REQ-031 The first accepted access SHALL be on the first rising edge with rst=0.

Structure
REQ-032 A shared package axi_ram_pkg SHALL hold the defaults for AXI_WIDTH, AXI_ADDR_WIDTH and DEPTH_LOG2, a function computing LSB, and a strobe-merge function (old word, new word, strobe -> merged word).
REQ-033 One sub-module axi_ram_bank SHALL hold the storage array with one read port and one byte-masked write port.
REQ-034 The top module SHALL contain the port arbitration, range check and counters.

Verification
REQ-035 Scenario 1: backdoor write 0x0011..EEFF to addr 5, then ren at addr 5 -> rdata equals that word one cycle later; rd_count=1.
REQ-036 Scenario 2: wen addr 5, wstrb=0x0001, wdata LSB byte 0xAA -> only byte 0 becomes 0xAA; backdoor read confirms; wr_count=1.
REQ-037 Scenario 3: same-cycle ren+wen at addr 7 (old 0x1, new 0x2) -> rdata=0x1 next cycle; subsequent read gives 0x2.
REQ-038 Scenario 4: ren at addr 2^DEPTH_LOG2 -> rdata=0 and oor_err=1; oor_err stays 1 for 100 further in-range accesses.
REQ-039 Scenario 5: assert rst mid-stream of back-to-back reads -> outputs zero immediately; memory retains prior backdoor data.
REQ-040 Scenario 6: 10,000 random ren/wen cycles against a scoreboard model -> zero mismatches; counters equal issued counts.

Source files
------------

// File: rtl/axi_ram_pkg.sv
// Shared defaults and helpers for the AXI RAM model: parameter defaults,
// word-to-byte address shift calculation and the byte-strobe merge.
package axi_ram_pkg;

  localparam int AXI_WIDTH_DEF      = 128;
  localparam int AXI_ADDR_WIDTH_DEF = 32;
  localparam int DEPTH_LOG2_DEF     = 12;

  // Widest word the merge helper handles; callers cast in and out of it.
  localparam int MERGE_MAX_W = 1024;

  // Which side of the bank a write came from (used for readability in the top).
  typedef enum logic [1:0] {
    WR_SRC_NONE = 2'd0,
    WR_SRC_PORT = 2'd1,
    WR_SRC_BD   = 2'd2
  } wr_src_e;

  // Number of byte-address bits below a word address.
  function automatic int calc_lsb(input int width);
    return $clog2(width) - 3;
  endfunction

  // Replace the bytes of old_word whose strobe bit is set with those of new_word.
  function automatic logic [MERGE_MAX_W-1:0] strb_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] strb
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int b = 0; b < MERGE_MAX_W / 8; b++) begin
      if (strb[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_ram_model_if.sv
// Bus bundle for the AXI RAM model: port read, port write, backdoor access
// and the status outputs. The RAM takes the slave view, the driver the master.
interface axi_ram_model_if
  import axi_ram_pkg::*;
#(
  parameter int AXI_WIDTH      = AXI_WIDTH_DEF,
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF
) ();

  localparam int LSB = calc_lsb(AXI_WIDTH);
  localparam int AW  = AXI_ADDR_WIDTH - LSB;

  // Port read
  logic                   ren;
  logic [AW-1:0]          raddr;
  logic [AXI_WIDTH-1:0]   rdata;
  // Port write
  logic                   wen;
  logic [AW-1:0]          waddr;
  logic [AXI_WIDTH-1:0]   wdata;
  logic [AXI_WIDTH/8-1:0] wstrb;
  // Backdoor
  logic                   bd_en;
  logic                   bd_we;
  logic [AW-1:0]          bd_addr;
  logic [AXI_WIDTH-1:0]   bd_wdata;
  logic [AXI_WIDTH-1:0]   bd_rdata;
  // Status
  logic [31:0]            rd_count;
  logic [31:0]            wr_count;
  logic                   oor_err;

  modport slave (
    input  ren, raddr, wen, waddr, wdata, wstrb,
    input  bd_en, bd_we, bd_addr, bd_wdata,
    output rdata, bd_rdata, rd_count, wr_count, oor_err
  );

  modport master (
    output ren, raddr, wen, waddr, wdata, wstrb,
    output bd_en, bd_we, bd_addr, bd_wdata,
    input  rdata, bd_rdata, rd_count, wr_count, oor_err
  );

endinterface

// File: rtl/axi_ram_bank.sv
// Storage array for the AXI RAM model. One registered read port and one
// byte-masked write port serve the bus side; a full-word backdoor read/write
// port sits alongside so that bus and backdoor traffic never stall each other.
// Reads are read-first. The caller guarantees both writes never target the
// same word in one cycle.
module axi_ram_bank
  import axi_ram_pkg::*;
#(
  parameter int WIDTH = AXI_WIDTH_DEF,
  parameter int IW    = DEPTH_LOG2_DEF
) (
  input  logic               clk,
  // Bus read port
  input  logic               rd_en_i,
  input  logic [IW-1:0]      rd_addr_i,
  output logic [WIDTH-1:0]   rd_data_o,
  // Bus byte-masked write port
  input  logic               wr_en_i,
  input  logic [IW-1:0]      wr_addr_i,
  input  logic [WIDTH-1:0]   wr_data_i,
  input  logic [WIDTH/8-1:0] wr_strb_i,
  // Backdoor port
  input  logic               bd_rd_en_i,
  input  logic               bd_wr_en_i,
  input  logic [IW-1:0]      bd_addr_i,
  input  logic [WIDTH-1:0]   bd_wdata_i,
  output logic [WIDTH-1:0]   bd_rdata_o
);

  logic [WIDTH-1:0] mem [0:(1<<IW)-1];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] bd_rdata_q;

  // Memory writes: backdoor full word, bus write merged through its strobes
  always_ff @(posedge clk) begin
    if (bd_wr_en_i) begin
      mem[bd_addr_i] <= bd_wdata_i;
    end
    if (wr_en_i) begin
      mem[wr_addr_i] <= WIDTH'(strb_merge(MERGE_MAX_W'(mem[wr_addr_i]),
                                          MERGE_MAX_W'(wr_data_i),
                                          (MERGE_MAX_W/8)'(wr_strb_i)));
    end
  end

  // Registered reads; the register holds when no read is requested
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
    if (bd_rd_en_i) begin
      bd_rdata_q <= mem[bd_addr_i];
    end
  end

  assign rd_data_o  = rd_data_q;
  assign bd_rdata_o = bd_rdata_q;

endmodule

// File: rtl/axi_ram_model.sv
// AXI RAM model top: range checks every access, arbitrates bus and backdoor
// writes onto the bank (bus write wins on a same-word collision), keeps the
// access counters and the sticky out-of-range flag. Read data leaving the
// bank is masked to zero after reset and after an out-of-range read, which
// lets the storage itself stay unreset.
module axi_ram_model
  import axi_ram_pkg::*;
#(
  parameter int AXI_WIDTH      = AXI_WIDTH_DEF,
  parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
  parameter int DEPTH_LOG2     = DEPTH_LOG2_DEF
) (
  input  logic           clk,
  input  logic           rst,
  axi_ram_model_if.slave bus
);

  localparam int LSB = calc_lsb(AXI_WIDTH);
  localparam int AW  = AXI_ADDR_WIDTH - LSB;
  localparam int IW  = DEPTH_LOG2;

  // An address is implemented only if every bit at or above DEPTH_LOG2 is zero.
  function automatic logic in_range(input logic [AW-1:0] addr);
    return (addr >> DEPTH_LOG2) == '0;
  endfunction

  logic                 r_inr;
  logic                 w_inr;
  logic                 bd_inr;
  logic                 rd_fire;
  logic                 wr_fire;
  logic                 bd_rd_fire;
  logic                 bd_wr_fire;
  wr_src_e              bd_slot_src;
  logic [AXI_WIDTH-1:0] bank_rdata;
  logic [AXI_WIDTH-1:0] bank_bd_rdata;

  logic                 rd_zero_q, rd_zero_d;
  logic                 bd_zero_q, bd_zero_d;
  logic [31:0]          rd_count_q, rd_count_d;
  logic [31:0]          wr_count_q, wr_count_d;
  logic                 oor_err_q, oor_err_d;

  assign r_inr  = in_range(bus.raddr);
  assign w_inr  = in_range(bus.waddr);
  assign bd_inr = in_range(bus.bd_addr);

  // Nothing reaches the array while reset is held, so the first access that
  // lands is on the first rising edge with rst low.
  assign rd_fire    = bus.ren & r_inr & ~rst;
  assign wr_fire    = bus.wen & w_inr & ~rst;
  assign bd_rd_fire = bus.bd_en & ~bus.bd_we & bd_inr & ~rst;

  // Decide who owns the backdoor write slot this cycle
  always_comb begin
    bd_slot_src = WR_SRC_NONE;
    if (bus.bd_en && bus.bd_we && bd_inr && !rst) begin
      if (wr_fire && (bus.bd_addr == bus.waddr)) begin
        bd_slot_src = WR_SRC_PORT;
      end else begin
        bd_slot_src = WR_SRC_BD;
      end
    end
  end

  assign bd_wr_fire = (bd_slot_src == WR_SRC_BD);

  axi_ram_bank #(
    .WIDTH (AXI_WIDTH),
    .IW    (IW)
  ) u_bank (
    .clk        (clk),
    .rd_en_i    (rd_fire),
    .rd_addr_i  (bus.raddr[IW-1:0]),
    .rd_data_o  (bank_rdata),
    .wr_en_i    (wr_fire),
    .wr_addr_i  (bus.waddr[IW-1:0]),
    .wr_data_i  (bus.wdata),
    .wr_strb_i  (bus.wstrb),
    .bd_rd_en_i (bd_rd_fire),
    .bd_wr_en_i (bd_wr_fire),
    .bd_addr_i  (bus.bd_addr[IW-1:0]),
    .bd_wdata_i (bus.bd_wdata),
    .bd_rdata_o (bank_bd_rdata)
  );

  // Next state of counters, sticky error and the read-data zero masks
  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    oor_err_d  = oor_err_q;
    rd_zero_d  = rd_zero_q;
    bd_zero_d  = bd_zero_q;
    if (bus.ren) begin
      rd_count_d = rd_count_q + 32'd1;
      rd_zero_d  = ~r_inr;
    end
    if (bus.wen) begin
      wr_count_d = wr_count_q + 32'd1;
    end
    if ((bus.ren && !r_inr) || (bus.wen && !w_inr)) begin
      oor_err_d = 1'b1;
    end
    if (bus.bd_en && !bus.bd_we) begin
      bd_zero_d = ~bd_inr;
    end
  end

  // Status and mask registers; reset forces every visible output to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
      oor_err_q  <= 1'b0;
      rd_zero_q  <= 1'b1;
      bd_zero_q  <= 1'b1;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      oor_err_q  <= oor_err_d;
      rd_zero_q  <= rd_zero_d;
      bd_zero_q  <= bd_zero_d;
    end
  end

  assign bus.rdata    = rd_zero_q ? '0 : bank_rdata;
  assign bus.bd_rdata = bd_zero_q ? '0 : bank_bd_rdata;
  assign bus.rd_count = rd_count_q;
  assign bus.wr_count = wr_count_q;
  assign bus.oor_err  = oor_err_q;

endmodule

// File: tb/tb_axi_ram_model.sv
// Bench for axi_ram_model: directed scenarios followed by a randomized run
// checked against a behavioural memory model with expected counters.
module tb_axi_ram_model;
  import axi_ram_pkg::*;

  localparam int W   = AXI_WIDTH_DEF;
  localparam int AWD = AXI_ADDR_WIDTH_DEF;
  localparam int DL  = DEPTH_LOG2_DEF;
  localparam int AW  = AWD - ($clog2(W) - 3);
  localparam int SW  = W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_ram_model_if #(.AXI_WIDTH(W), .AXI_ADDR_WIDTH(AWD)) bus ();

  axi_ram_model #(
    .AXI_WIDTH      (W),
    .AXI_ADDR_WIDTH (AWD),
    .DEPTH_LOG2     (DL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_rd   = 0;
  int exp_wr   = 0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit inr(input logic [AW-1:0] a);
    return a < AW'(1 << DL);
  endfunction

  function automatic logic [AW-1:0] gen_addr();
    if ($urandom_range(0, 15) == 0) return AW'($urandom_range(1 << DL, (1 << AW) - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic clear_inputs();
    bus.ren = 1'b0; bus.raddr = '0;
    bus.wen = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.wstrb = '0;
    bus.bd_en = 1'b0; bus.bd_we = 1'b0; bus.bd_addr = '0; bus.bd_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle with optional read and write; tracks expected counters
  task automatic port_cycle(input bit r, input logic [AW-1:0] ra,
                            input bit w, input logic [AW-1:0] wa,
                            input logic [W-1:0] wd, input logic [SW-1:0] ws);
    bus.ren = r; bus.raddr = ra;
    bus.wen = w; bus.waddr = wa; bus.wdata = wd; bus.wstrb = ws;
    step();
    if (r) exp_rd++;
    if (w) exp_wr++;
    $display("txn port ren=%0b raddr=%h wen=%0b waddr=%h wstrb=%h", r, ra, w, wa, ws);
    bus.ren = 1'b0; bus.wen = 1'b0;
  endtask

  task automatic bd_cycle(input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    bus.bd_en = 1'b1; bus.bd_we = we; bus.bd_addr = a; bus.bd_wdata = d;
    step();
    $display("txn backdoor we=%0b addr=%h data=%h", we, a, d);
    bus.bd_en = 1'b0; bus.bd_we = 1'b0;
  endtask

  logic [W-1:0] mdl [0:15];
  logic [W-1:0] w1, exp_word, keep20, exp_rdata, exp_bd, wd, bwd;
  logic [AW-1:0] ra, wa, ba;
  logic [SW-1:0] ws;
  bit r, w, bden, bdwe, exp_oor;

  initial begin
    clear_inputs();

    // Reset state
    #12;
    check_eq("reset_rdata",    bus.rdata, '0);
    check_eq("reset_bd_rdata", bus.bd_rdata, '0);
    check_eq("reset_rd_count", W'(bus.rd_count), '0);
    check_eq("reset_wr_count", W'(bus.wr_count), '0);
    check_eq("reset_oor",      W'(bus.oor_err), '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Scenario 1: backdoor write then port read
    w1 = 128'h00112233445566778899AABBCCDDEEFF;
    bd_cycle(1'b1, AW'(5), w1);
    port_cycle(1'b1, AW'(5), 1'b0, '0, '0, '0);
    check_eq("s1_rdata", bus.rdata, w1);
    check_eq("s1_rd_count", W'(bus.rd_count), W'(1));
    step();
    check_eq("s1_rdata_hold", bus.rdata, w1);

    // Scenario 2: single-byte strobe write
    wd = rand_word();
    wd[7:0] = 8'hAA;
    port_cycle(1'b0, '0, 1'b1, AW'(5), wd, SW'(1));
    bd_cycle(1'b0, AW'(5), '0);
    exp_word = w1;
    exp_word[7:0] = 8'hAA;
    check_eq("s2_bd_rdata", bus.bd_rdata, exp_word);
    check_eq("s2_wr_count", W'(bus.wr_count), W'(1));
    check_eq("s2_rdata_hold", bus.rdata, w1);

    // Scenario 3: same-cycle read and write is read-first
    bd_cycle(1'b1, AW'(7), W'(1));
    port_cycle(1'b1, AW'(7), 1'b1, AW'(7), W'(2), '1);
    check_eq("s3_read_first", bus.rdata, W'(1));
    port_cycle(1'b1, AW'(7), 1'b0, '0, '0, '0);
    check_eq("s3_read_new", bus.rdata, W'(2));

    // Scenario 4: last implemented word, then out of range read
    bd_cycle(1'b1, AW'((1 << DL) - 1), ~w1);
    port_cycle(1'b1, AW'((1 << DL) - 1), 1'b0, '0, '0, '0);
    check_eq("s4_top_word", bus.rdata, ~w1);
    check_eq("s4_oor_clear", W'(bus.oor_err), '0);
    port_cycle(1'b1, AW'(1 << DL), 1'b0, '0, '0, '0);
    check_eq("s4_oor_rdata", bus.rdata, '0);
    check_eq("s4_oor_set", W'(bus.oor_err), W'(1));
    for (int i = 0; i < 100; i++) begin
      port_cycle(i % 2 == 0, AW'(100 + i), i % 2 == 1, AW'(200 + i), rand_word(), '1);
      check_eq("s4_oor_sticky", W'(bus.oor_err), W'(1));
    end
    check_eq("s4_rd_count", W'(bus.rd_count), W'(exp_rd));
    check_eq("s4_wr_count", W'(bus.wr_count), W'(exp_wr));

    // Scenario 5: asynchronous reset in the middle of back-to-back reads
    keep20 = rand_word();
    bd_cycle(1'b1, AW'(20), keep20);
    bd_cycle(1'b1, AW'(21), ~keep20);
    port_cycle(1'b1, AW'(20), 1'b0, '0, '0, '0);
    check_eq("s5_read20", bus.rdata, keep20);
    bus.ren = 1'b1; bus.raddr = AW'(21);
    #3;
    rst = 1'b1;
    #1;
    check_eq("s5_rst_rdata", bus.rdata, '0);
    check_eq("s5_rst_bd_rdata", bus.bd_rdata, '0);
    check_eq("s5_rst_rd_count", W'(bus.rd_count), '0);
    check_eq("s5_rst_wr_count", W'(bus.wr_count), '0);
    check_eq("s5_rst_oor", W'(bus.oor_err), '0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    bus.ren = 1'b0;
    exp_rd = 0;
    exp_wr = 0;
    step();
    check_eq("s5_discarded_read", bus.rdata, '0);
    bd_cycle(1'b0, AW'(20), '0);
    check_eq("s5_mem_kept20", bus.bd_rdata, keep20);
    check_eq("s5_rd_count_after", W'(bus.rd_count), '0);

    // Scenario 6: randomized traffic against a behavioural model
    for (int i = 0; i < 16; i++) begin
      mdl[i] = rand_word();
      bd_cycle(1'b1, AW'(i), mdl[i]);
    end
    exp_rdata = '0;
    exp_bd    = keep20;
    exp_oor   = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      r    = 1'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      ra   = gen_addr();
      wa   = gen_addr();
      wd   = rand_word();
      ws   = SW'($urandom);
      bden = ($urandom_range(0, 3) == 0);
      bdwe = 1'($urandom_range(0, 1));
      ba   = gen_addr();
      bwd  = rand_word();
      // expected reads see the memory as it was before this cycle's writes
      if (r) exp_rdata = inr(ra) ? mdl[ra[3:0]] : '0;
      if (bden && !bdwe) exp_bd = inr(ba) ? mdl[ba[3:0]] : '0;
      if (bden && bdwe && inr(ba) && !(w && inr(wa) && wa == ba)) mdl[ba[3:0]] = bwd;
      if (w && inr(wa)) begin
        for (int b = 0; b < SW; b++) begin
          if (ws[b]) mdl[wa[3:0]][b*8 +: 8] = wd[b*8 +: 8];
        end
      end
      if ((r && !inr(ra)) || (w && !inr(wa))) exp_oor = 1'b1;
      if (r) exp_rd++;
      if (w) exp_wr++;
      bus.ren = r; bus.raddr = ra;
      bus.wen = w; bus.waddr = wa; bus.wdata = wd; bus.wstrb = ws;
      bus.bd_en = bden; bus.bd_we = bdwe; bus.bd_addr = ba; bus.bd_wdata = bwd;
      step();
      check_eq("s6_rdata", bus.rdata, exp_rdata);
      check_eq("s6_bd_rdata", bus.bd_rdata, exp_bd);
    end
    clear_inputs();
    step();
    check_eq("s6_rd_count", W'(bus.rd_count), W'(exp_rd));
    check_eq("s6_wr_count", W'(bus.wr_count), W'(exp_wr));
    check_eq("s6_oor", W'(bus.oor_err), W'(exp_oor));
    for (int i = 0; i < 16; i++) begin
      bd_cycle(1'b0, AW'(i), '0);
      check_eq("s6_final_mem", bus.bd_rdata, mdl[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
